// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and requester indices.
package dmem_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_CORE = 1'b0;
  localparam req_idx_t REQ_DMA  = 1'b1;

  function automatic req_idx_t other_req(input req_idx_t k);
    return ~k;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 32
);

  logic                    i_req0_valid;
  logic                    i_req1_valid;
  logic                    o_req0_ready;
  logic                    o_req1_ready;
  logic                    i_req0_we;
  logic                    i_req1_we;
  logic [P_ADDR_WIDTH-1:0] i_req0_addr;
  logic [P_ADDR_WIDTH-1:0] i_req1_addr;
  logic [P_DATA_WIDTH-1:0] i_req0_wdata;
  logic [P_DATA_WIDTH-1:0] i_req1_wdata;
  logic                    o_rsp0_valid;
  logic                    o_rsp1_valid;
  logic [P_DATA_WIDTH-1:0] o_rsp0_rdata;
  logic [P_DATA_WIDTH-1:0] o_rsp1_rdata;
  logic                    o_mem_we;
  logic [P_ADDR_WIDTH-1:0] o_mem_addr;
  logic [P_DATA_WIDTH-1:0] o_mem_wdata;
  logic [P_DATA_WIDTH-1:0] i_mem_rdata;
  logic                    o_init_done;

  modport slave (
    input  i_req0_valid, i_req1_valid, i_req0_we, i_req1_we,
    input  i_req0_addr, i_req1_addr, i_req0_wdata, i_req1_wdata,
    input  i_mem_rdata,
    output o_req0_ready, o_req1_ready,
    output o_rsp0_valid, o_rsp1_valid, o_rsp0_rdata, o_rsp1_rdata,
    output o_mem_we, o_mem_addr, o_mem_wdata, o_init_done
  );

  modport master (
    output i_req0_valid, i_req1_valid, i_req0_we, i_req1_we,
    output i_req0_addr, i_req1_addr, i_req0_wdata, i_req1_wdata,
    output i_mem_rdata,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp0_valid, o_rsp1_valid, o_rsp0_rdata, o_rsp1_rdata,
    input  o_mem_we, o_mem_addr, o_mem_wdata, o_init_done
  );

endinterface

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser.
module dmem_rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant,
  output logic       o_any,
  output req_idx_t   o_idx
);

  req_idx_t ptr;

  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    o_idx   = ptr;
    if (i_en) begin
      if (&i_valid) begin
        o_idx = ptr;
        o_any = 1'b1;
      end else if (i_valid[0]) begin
        o_idx = REQ_CORE;
        o_any = 1'b1;
      end else if (i_valid[1]) begin
        o_idx = REQ_DMA;
        o_any = 1'b1;
      end
      if (o_any) o_grant[o_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr <= REQ_CORE;
    end else if (o_any) begin
      ptr <= other_req(o_idx);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory front end: zero-fills memory after reset/clear, then arbitrates
// two requesters onto a single-port asynchronous-read memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  dmem_arbiter_if.slave bus
);

  state_t                  state, state_nxt;
  logic [P_ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;

  logic [1:0]              grant;
  logic                    grant_any;
  req_idx_t                grant_idx;
  logic                    arb_en;

  logic                    rd_hs0, rd_hs1;
  logic                    rsp0_valid, rsp1_valid;
  logic [P_DATA_WIDTH-1:0] rsp0_rdata, rsp1_rdata;

  logic                    mem_we;
  logic [P_ADDR_WIDTH-1:0] mem_addr;
  logic [P_DATA_WIDTH-1:0] mem_wdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        if (i_clear) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Requests are refused in the cycle a clear is requested.
  assign arb_en = (state == RUN) && !i_clear;

  dmem_rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (arb_en),
    .i_valid ({bus.i_req1_valid, bus.i_req0_valid}),
    .o_grant (grant),
    .o_any   (grant_any),
    .o_idx   (grant_idx)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt;
    end else if (grant_any) begin
      if (grant_idx == REQ_DMA) begin
        mem_we    = bus.i_req1_we;
        mem_addr  = bus.i_req1_addr;
        mem_wdata = bus.i_req1_wdata;
      end else begin
        mem_we    = bus.i_req0_we;
        mem_addr  = bus.i_req0_addr;
        mem_wdata = bus.i_req0_wdata;
      end
    end
  end

  assign rd_hs0 = grant[0] && !bus.i_req0_we;
  assign rd_hs1 = grant[1] && !bus.i_req1_we;

  // Response registers are independent of the FSM so a read accepted just
  // before a clear still returns its data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= rd_hs0;
      rsp1_valid <= rd_hs1;
      if (rd_hs0) rsp0_rdata <= bus.i_mem_rdata;
      if (rd_hs1) rsp1_rdata <= bus.i_mem_rdata;
    end
  end

  assign bus.o_req0_ready = grant[0];
  assign bus.o_req1_ready = grant[1];
  assign bus.o_rsp0_valid = rsp0_valid;
  assign bus.o_rsp1_valid = rsp1_valid;
  assign bus.o_rsp0_rdata = rsp0_rdata;
  assign bus.o_rsp1_rdata = rsp1_rdata;
  assign bus.o_mem_we     = mem_we;
  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_wdata  = mem_wdata;
  assign bus.o_init_done  = (state == RUN);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural memory/arbitration model.
module tb_dmem_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (bus)
  );

  // Physical memory attached to the DUT's memory port.
  logic [DW-1:0] phys [DEPTH];
  always @(posedge clk) if (bus.o_mem_we) phys[bus.o_mem_addr] <= bus.o_mem_wdata;
  assign bus.i_mem_rdata = phys[bus.o_mem_addr];

  rsp_t q0[$];
  rsp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, clear progress and round-robin pointer.
  bit            m_live = 0;
  bit            m_run  = 0;
  int            m_ccnt = 0;
  int            m_ptr  = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  always @(negedge clk) begin : model
    int            g;
    logic [1:0]    v, w, er;
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    v    = {bus.i_req1_valid, bus.i_req0_valid};
    w    = {bus.i_req1_we, bus.i_req0_we};
    a[0] = bus.i_req0_addr;  a[1] = bus.i_req1_addr;
    d[0] = bus.i_req0_wdata; d[1] = bus.i_req1_wdata;
    g = -1; ew = 1'b0; ea = '0; ed = '0; er = '0;
    if (m_live) begin
      if (!m_run) begin
        ew = 1'b1;
        ea = AW'(m_ccnt);
      end else if (!clear) begin
        if (v == 2'b11) g = m_ptr;
        else if (v[0]) g = 0;
        else if (v[1]) g = 1;
        if (g >= 0) begin
          er[g] = 1'b1; ew = w[g]; ea = a[g]; ed = d[g];
        end
      end
      chk("init_done", 32'(bus.o_init_done), 32'(m_run));
      chk("req0_ready", 32'(bus.o_req0_ready), 32'(er[0]));
      chk("req1_ready", 32'(bus.o_req1_ready), 32'(er[1]));
      chk("mem_we", 32'(bus.o_mem_we), 32'(ew));
      chk("mem_addr", 32'(bus.o_mem_addr), 32'(ea));
      chk("mem_wdata", bus.o_mem_wdata, ed);
      if (rst_n) begin
        if (g >= 0) begin
          m_ptr = 1 - g;
          if (w[g]) ref_mem[a[g]] = d[g];
          else if (g == 0) q0.push_back('{cyc + 1, ref_mem[a[0]]});
          else q1.push_back('{cyc + 1, ref_mem[a[1]]});
        end
        if (!m_run) begin
          if (m_ccnt == DEPTH - 1) begin
            m_run = 1;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
          end else begin
            m_ccnt++;
          end
        end else if (clear) begin
          m_run  = 0;
          m_ccnt = 0;
        end
      end
    end
    if (!rst_n) begin
      m_live = 1; m_run = 0; m_ccnt = 0; m_ptr = 0;
    end
  end

  // Monitor: pops expected responses when due and tracks held read data.
  bit            mon_live = 0;
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;

  always @(negedge clk) begin : monitor
    bit due;
    if (mon_live) begin
      due = (q0.size() > 0) && (q0[0].due == cyc);
      if (due || bus.o_rsp0_valid) chk("rsp0_valid", 32'(bus.o_rsp0_valid), 32'(due));
      if (due) begin
        exp_rd0 = q0[0].data;
        void'(q0.pop_front());
      end
      chk("rsp0_rdata", bus.o_rsp0_rdata, exp_rd0);
      due = (q1.size() > 0) && (q1[0].due == cyc);
      if (due || bus.o_rsp1_valid) chk("rsp1_valid", 32'(bus.o_rsp1_valid), 32'(due));
      if (due) begin
        exp_rd1 = q1[0].data;
        void'(q1.pop_front());
      end
      chk("rsp1_rdata", bus.o_rsp1_rdata, exp_rd1);
    end
    if (!rst_n) begin
      mon_live = 1;
      exp_rd0  = '0;
      exp_rd1  = '0;
    end
  end

  task automatic idle_inputs();
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    bus.i_req0_we    = 1'b0; bus.i_req1_we    = 1'b0;
    bus.i_req0_addr  = '0;   bus.i_req1_addr  = '0;
    bus.i_req0_wdata = '0;   bus.i_req1_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.o_init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("init_timeout", 32'(n < 100), 32'd1);
    step();
  endtask

  // Caller is just after a rising edge; returns just after the edge that follows the handshake.
  task automatic issue(input int k, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n = 0;
    if (k == 0) begin
      bus.i_req0_valid = 1'b1; bus.i_req0_we = we; bus.i_req0_addr = addr; bus.i_req0_wdata = data;
    end else begin
      bus.i_req1_valid = 1'b1; bus.i_req1_we = we; bus.i_req1_addr = addr; bus.i_req1_wdata = data;
    end
    @(negedge clk);
    while (!(k == 0 ? bus.o_req0_ready : bus.o_req1_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_timeout", 32'(n < 50), 32'd1);
    step();
    if (k == 0) bus.i_req0_valid = 1'b0;
    else bus.i_req1_valid = 1'b0;
  endtask

  initial begin : driver
    int n, c0, c1;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full clear after reset release: 16 cycles before init_done.
    n = 0;
    @(negedge clk);
    while (!bus.o_init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("clear_len", 32'(n), 32'd16);
    step();

    issue(0, 1'b1, 4'd5, 32'hDEADBEEF);
    issue(0, 1'b0, 4'd5, '0);
    repeat (2) step();

    // Continuous contention: grants alternate.
    bus.i_req0_valid = 1'b1; bus.i_req0_we = 1'b0; bus.i_req0_addr = 4'd1;
    bus.i_req1_valid = 1'b1; bus.i_req1_we = 1'b0; bus.i_req1_addr = 4'd2;
    c0 = 0; c1 = 0;
    repeat (8) begin
      @(negedge clk);
      c0 += int'(bus.o_req0_ready);
      c1 += int'(bus.o_req1_ready);
      step();
    end
    idle_inputs();
    chk("rr_count0", 32'(c0), 32'd4);
    chk("rr_count1", 32'(c1), 32'd4);
    repeat (3) step();

    // Clear with a pending req1 read: served only after the clear completes.
    clear = 1'b1;
    bus.i_req1_valid = 1'b1; bus.i_req1_we = 1'b0; bus.i_req1_addr = 4'd5;
    n = 0;
    @(negedge clk);
    while (!bus.o_req1_ready && n < 40) begin
      step();
      clear = 1'b0;
      n++;
      @(negedge clk);
    end
    clear = 1'b0;
    chk("clear_wait", 32'(n), 32'd17);
    chk("clear_done_at_grant", 32'(bus.o_init_done), 32'd1);
    step();
    idle_inputs();
    wait_done();

    // Reset in the middle of a clear, with the counter at 9.
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (9) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_clear_addr", 32'(bus.o_mem_addr), 32'd9);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("rst_rsp0_valid", 32'(bus.o_rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(bus.o_rsp1_valid), 32'd0);
    chk("rst_init_done", 32'(bus.o_init_done), 32'd0);
    wait_done();

    // Write-only traffic from req1 leaves its read data untouched.
    issue(1, 1'b1, 4'd7, 32'hCAFE0001);
    issue(1, 1'b0, 4'd7, '0);
    issue(1, 1'b1, 4'd3, 32'h00001234);
    repeat (5) step();

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      clear = ($urandom_range(0, 99) == 0);
      bus.i_req0_valid = rst_n && ($urandom_range(0, 2) != 0);
      bus.i_req1_valid = rst_n && ($urandom_range(0, 2) != 0);
      bus.i_req0_we    = $urandom_range(0, 1) == 1;
      bus.i_req1_we    = $urandom_range(0, 1) == 1;
      bus.i_req0_addr  = AW'($urandom);
      bus.i_req1_addr  = AW'($urandom);
      bus.i_req0_wdata = $urandom;
      bus.i_req1_wdata = $urandom;
      step();
    end
    idle_inputs();
    rst_n = 1'b1;
    clear = 1'b0;
    repeat (5) step();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter P_ADDR_WIDTH, default 8, giving the memory word-address width (2**P_ADDR_WIDTH words).
REQ-002 The block SHALL have parameter P_DATA_WIDTH, default 32, giving the data word width.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port i_clear, input, 1 bit: one-cycle request to re-zero the whole memory.
REQ-006 Ports i_req0_valid / i_req1_valid, input, 1 bit each: request valid for requester 0 (core) and requester 1 (DMA/debug).
REQ-007 Ports o_req0_ready / o_req1_ready, output, 1 bit each: request accepted this cycle.
REQ-008 Ports i_req0_we / i_req1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-009 Ports i_req0_addr / i_req1_addr, input, P_ADDR_WIDTH bits each: word address.
REQ-010 Ports i_req0_wdata / i_req1_wdata, input, P_DATA_WIDTH bits each: write data.
REQ-011 Ports o_rsp0_valid / o_rsp1_valid, output, 1 bit each: read data valid, one-cycle pulse.
REQ-012 Ports o_rsp0_rdata / o_rsp1_rdata, output, P_DATA_WIDTH bits each: registered read data.
REQ-013 Ports o_mem_we (1 bit), o_mem_addr (P_ADDR_WIDTH bits) and o_mem_wdata (P_DATA_WIDTH bits), outputs: drive the memory write-enable, address and write data.
REQ-014 Port i_mem_rdata, input, P_DATA_WIDTH bits: the memory's combinational (asynchronous) read data.
REQ-015 Port o_init_done, output, 1 bit: high in state RUN.

Function
REQ-016 The FSM SHALL have exactly two states, CLEAR and RUN.
REQ-017 In CLEAR: o_mem_we=1, o_mem_addr=clear counter, o_mem_wdata=0, both readies=0; the counter increments by 1 each cycle.
REQ-018 CLEAR SHALL go to RUN on the cycle after the counter reaches 2**P_ADDR_WIDTH-1, so a full clear takes 2**P_ADDR_WIDTH cycles.
REQ-019 In RUN with i_clear=1: the block SHALL enter CLEAR on the next edge with the counter set to 0, accept no request that cycle, and ignore i_clear while in CLEAR.
REQ-020 Grant in RUN: one requester per cycle, combinational; a lone valid requester is granted.
REQ-021 When both requesters are valid, the requester holding the priority pointer SHALL be granted.
REQ-022 After any grant, the priority pointer SHALL move to the non-granted requester (round-robin).
REQ-023 o_reqK_ready SHALL be 1 only when in RUN, i_clear=0 and requester K is granted; the handshake is valid&&ready.
REQ-024 The memory-side outputs SHALL follow the granted request: o_mem_we = grantee valid&&we; o_mem_addr and o_mem_wdata from the grantee.
REQ-025 With no grant, o_mem_we SHALL be 0 and o_mem_addr/o_mem_wdata SHALL be 0.
REQ-026 Read handshake: i_mem_rdata SHALL be captured into o_rspK_rdata, and o_rspK_valid SHALL pulse for exactly the next cycle (latency 1).
REQ-027 Write handshakes SHALL produce no response; o_rspK_rdata SHALL hold its value until the next read by requester K.
REQ-028 A read response whose handshake precedes an i_clear cycle SHALL still be delivered.
REQ-029 Back-to-back reads by the same requester SHALL produce consecutive response pulses with no bubble.

Reset
REQ-030 When i_rst_n=0 at a rising edge, the block SHALL reset to: state CLEAR, counter 0, pointer = requester 0, o_rspK_valid=0, o_rspK_rdata=0.
REQ-031 After reset, o_init_done SHALL be 0 until CLEAR completes; reset asserted mid-CLEAR or mid-RUN SHALL restart the clear from address 0.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold the state enum (CLEAR, RUN) and the requester-index typedef.
REQ-033 The two-way round-robin grant logic and pointer SHALL be one sub-module, dmem_rr_arb2; everything else stays in dmem_arbiter.

Verification
REQ-034 Reset release with P_ADDR_WIDTH=4 -> 16 cycles of o_mem_we=1, addresses 0..15, data 0, then o_init_done=1.
REQ-035 Req0 writes 0xDEADBEEF to address 5, then reads address 5 -> o_rsp0_valid one cycle after the read handshake with 0xDEADBEEF.
REQ-036 Both requesters valid continuously, reading addresses 1 and 2 -> grants alternate 0,1,0,1; each requester gets a response every other cycle.
REQ-037 i_clear asserted in the same cycle as a pending req1 read -> no ready that cycle, full clear runs, and the request is granted after o_init_done.
REQ-038 i_rst_n pulsed low with the counter at 9 -> the clear restarts at address 0 and rsp valids are 0.
REQ-039 Req1 writes 0x1234 and there is no subsequent read -> no o_rsp1_valid pulse, o_rsp1_rdata unchanged.
